// File: rtl/omni_tx_arbiter.sv
// Per-beat round-robin arbiter merging NUM_PORTS AXI-Stream requesters into one registered output.
// Define OMNI_ARB_LOOPBACK_PRIO_EN to give the loopback port (NUM_PORTS-1) strict priority.
module omni_tx_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int DATA_W    = 528
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [NUM_PORTS*DATA_W-1:0]    rx_TDATA,
    input  logic [NUM_PORTS-1:0]           rx_TVALID,
    output logic [NUM_PORTS-1:0]           rx_TREADY,
    output logic [DATA_W-1:0]              tx_TDATA,
    output logic                           tx_TVALID,
    input  logic                           tx_TREADY,
    output logic [$clog2(NUM_PORTS)-1:0]   grant_idx,
    output logic [31:0]                    beat_cnt
);

    localparam int                 PTR_W = $clog2(NUM_PORTS);
    localparam logic [PTR_W-1:0]   LAST  = PTR_W'(NUM_PORTS - 1);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_next;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] scan;
    logic             found;
    logic             accept;
    logic             rx_hs;
    logic             tx_hs;

    assign accept = !tx_TVALID || tx_TREADY;
    assign tx_hs  = tx_TVALID && tx_TREADY;
    // Ready is held low during reset even though the empty output stage would accept.
    assign rx_hs  = aresetn && accept && (|rx_TVALID);

    // First valid requester at or after rr_ptr, modulo NUM_PORTS.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        winner = '0;
        found  = 1'b0;
        scan   = '0;
`ifdef OMNI_ARB_LOOPBACK_PRIO_EN
        if (rx_TVALID[NUM_PORTS-1]) begin
            winner = LAST;
            found  = 1'b1;
        end
`endif
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan = PTR_W'((int'(rr_ptr) + k) % NUM_PORTS);
            if (!found && rx_TVALID[scan]) begin
                winner = scan;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        rr_next = (winner == LAST) ? '0 : winner + PTR_W'(1);
`ifdef OMNI_ARB_LOOPBACK_PRIO_EN
        // Loopback wins outside the rotation, so it must not disturb the pointer.
        if (winner == LAST) rr_next = rr_ptr;
`endif
    end

    assign rx_TREADY = rx_hs ? (NUM_PORTS'(1) << winner) : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // NOTE: the data register is reset too, so a beat caught by reset can never be replayed.
            tx_TVALID <= 1'b0;
            tx_TDATA  <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
        end else begin
            if (rx_hs) begin
                tx_TVALID <= 1'b1;
                tx_TDATA  <= rx_TDATA[winner*DATA_W +: DATA_W];
                grant_idx <= winner;
                rr_ptr    <= rr_next;
            end else if (tx_hs) begin
                tx_TVALID <= 1'b0;
            end
            if (tx_hs) beat_cnt <= beat_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_omni_tx_arbiter.sv
// Scoreboard bench for omni_tx_arbiter: a negedge reference model predicts rx_TREADY and queues
// expected beats; scenario tasks add targeted checks for the documented corner cases.
module tb_omni_tx_arbiter;

    localparam int N  = 5;
    localparam int W  = 528;
    localparam int PW = $clog2(N);

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [N*W-1:0]    rx_TDATA = '0;
    logic [N-1:0]      rx_TVALID = '0;
    logic [N-1:0]      rx_TREADY;
    logic [W-1:0]      tx_TDATA;
    logic              tx_TVALID;
    logic              tx_TREADY = 1'b1;
    logic [PW-1:0]     grant_idx;
    logic [31:0]       beat_cnt;

    omni_tx_arbiter #(.NUM_PORTS(N), .DATA_W(W)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .rx_TDATA  (rx_TDATA),
        .rx_TVALID (rx_TVALID),
        .rx_TREADY (rx_TREADY),
        .tx_TDATA  (tx_TDATA),
        .tx_TVALID (tx_TVALID),
        .tx_TREADY (tx_TREADY),
        .grant_idx (grant_idx),
        .beat_cnt  (beat_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [PW-1:0] idx;
        logic [W-1:0]  data;
    } beat_t;

    beat_t       sb[$];
    int          errors = 0;
    int          checks = 0;
    logic        m_valid = 1'b0;
    logic [PW-1:0] m_rr = '0;
    logic [31:0] m_cnt = '0;

    function automatic logic [W-1:0] beat_of(int port, int seed);
        return {16'(seed * 16 + port), {16{32'(32'hC0DE_0000 + seed * 256 + port)}}};
    endfunction

    function automatic int model_winner(logic [N-1:0] v, logic [PW-1:0] rr);
`ifdef OMNI_ARB_LOOPBACK_PRIO_EN
        if (v[N-1]) return N - 1;
`endif
        for (int k = 0; k < N; k++) begin
            int p;
            p = (int'(rr) + k) % N;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    task automatic set_data(int seed);
        for (int i = 0; i < N; i++) rx_TDATA[i*W +: W] = beat_of(i, seed);
    endtask

    task automatic reset_dut();
        aresetn   = 1'b0;
        rx_TVALID = '0;
        tx_TREADY = 1'b1;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    // Reference model: compares current outputs, then advances to the state after the next edge.
    always @(negedge aclk) begin
        if (!aresetn) begin
            sb.delete();
            m_valid = 1'b0;
            m_rr    = '0;
            m_cnt   = '0;
        end else begin
            automatic int         w   = model_winner(rx_TVALID, m_rr);
            automatic logic       acc = !m_valid || tx_TREADY;
            automatic logic [N-1:0] er = (acc && w >= 0) ? (N'(1) << w) : '0;
            checks++;
            if (rx_TREADY !== er) begin
                errors++;
                $display("FAIL sb_rx_ready t=%0t got=%b want=%b", $time, rx_TREADY, er);
            end
            checks++;
            if (tx_TVALID !== m_valid) begin
                errors++;
                $display("FAIL sb_tx_valid t=%0t got=%b want=%b", $time, tx_TVALID, m_valid);
            end
            checks++;
            if (beat_cnt !== m_cnt) begin
                errors++;
                $display("FAIL sb_beat_cnt t=%0t got=%0d want=%0d", $time, beat_cnt, m_cnt);
            end
            if (m_valid) begin
                checks++;
                if (sb.size() == 0 || tx_TDATA !== sb[0].data || grant_idx !== sb[0].idx) begin
                    errors++;
                    $display("FAIL sb_beat t=%0t got idx=%0d data=%h want idx=%0d data=%h",
                             $time, grant_idx, tx_TDATA, sb.size() ? sb[0].idx : '0,
                             sb.size() ? sb[0].data : '0);
                end
                if (tx_TREADY) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                    m_cnt = m_cnt + 32'd1;
                end
            end
            if (er != '0) begin
                sb.push_back('{idx: PW'(w), data: rx_TDATA[w*W +: W]});
                m_valid = 1'b1;
`ifdef OMNI_ARB_LOOPBACK_PRIO_EN
                if (w != N - 1) m_rr = (w == N - 1) ? '0 : PW'(w + 1);
`else
                m_rr = (w == N - 1) ? '0 : PW'(w + 1);
`endif
            end else if (m_valid && tx_TREADY) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic test_reset();
        set_data(0);
        rx_TVALID = '1;
        #2;
        checks++;
        if ({tx_TVALID, grant_idx, beat_cnt} !== '0 || tx_TDATA !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b g=%0d cnt=%0d data=%h want all zero",
                     tx_TVALID, grant_idx, beat_cnt, tx_TDATA);
        end
        checks++;
        if (rx_TREADY !== '0) begin
            errors++;
            $display("FAIL reset_rx_ready got=%b want=00000", rx_TREADY);
        end
        @(posedge aclk); #1;
        checks++;
        if (tx_TVALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_valid got=%b want=0", tx_TVALID);
        end
        rx_TVALID = '0;
        @(posedge aclk); #1 aresetn = 1'b1;
    endtask

    task automatic test_single_port();
        logic [W-1:0] a5;
        a5 = {66{8'hA5}};
        set_data(1);
        rx_TDATA[2*W +: W] = a5;
        rx_TVALID = 5'b00100;
        @(negedge aclk);
        checks++;
        if (rx_TREADY !== 5'b00100) begin
            errors++;
            $display("FAIL single_ready got=%b want=00100", rx_TREADY);
        end
        @(posedge aclk); #1 rx_TVALID = '0;
        checks++;
        if (tx_TVALID !== 1'b1 || grant_idx !== 3'd2 || tx_TDATA !== a5) begin
            errors++;
            $display("FAIL single_beat got v=%b g=%0d data=%h want v=1 g=2 data=%h",
                     tx_TVALID, grant_idx, tx_TDATA, a5);
        end
        rx_TVALID = 5'b01010;
        @(negedge aclk);
        checks++;
        if (rx_TREADY !== 5'b01000) begin
            errors++;
            $display("FAIL single_rr_ptr3 got=%b want=01000", rx_TREADY);
        end
        @(posedge aclk); #1 rx_TVALID = '0;
        checks++;
        if (grant_idx !== 3'd3) begin
            errors++;
            $display("FAIL single_next_grant got=%0d want=3", grant_idx);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_round_robin();
        reset_dut();
        set_data(2);
        rx_TVALID = '1;
        for (int i = 0; i < 10; i++) begin
            @(posedge aclk); #1;
            if (i == 9) rx_TVALID = '0;
            checks++;
            if (tx_TVALID !== 1'b1 || grant_idx !== PW'(i % N)) begin
                errors++;
                $display("FAIL rr_seq[%0d] got v=%b g=%0d want v=1 g=%0d", i, tx_TVALID, grant_idx, i % N);
            end
        end
        @(posedge aclk); #1;
        checks++;
        if (tx_TVALID !== 1'b0 || beat_cnt !== 32'd10) begin
            errors++;
            $display("FAIL rr_count got v=%b cnt=%0d want v=0 cnt=10", tx_TVALID, beat_cnt);
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        set_data(3);
        rx_TVALID = 5'b01001;
        @(posedge aclk); #1 tx_TREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            checks++;
            if (rx_TREADY !== '0) begin
                errors++;
                $display("FAIL bp_ready[%0d] got=%b want=00000", i, rx_TREADY);
            end
            @(posedge aclk); #1;
            checks++;
            if (tx_TVALID !== 1'b1 || grant_idx !== 3'd0 || tx_TDATA !== beat_of(0, 3)) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b g=%0d data=%h want v=1 g=0 data=%h",
                         i, tx_TVALID, grant_idx, tx_TDATA, beat_of(0, 3));
            end
        end
        tx_TREADY = 1'b1;
        @(negedge aclk);
        checks++;
        if (rx_TREADY !== 5'b01000) begin
            errors++;
            $display("FAIL bp_release_ready got=%b want=01000", rx_TREADY);
        end
        @(posedge aclk); #1 rx_TVALID = '0;
        checks++;
        if (grant_idx !== 3'd3) begin
            errors++;
            $display("FAIL bp_release_grant got=%0d want=3", grant_idx);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_reset_mid();
        set_data(4);
        rx_TVALID = 5'b00010;
        tx_TREADY = 1'b0;
        @(posedge aclk); #1 rx_TVALID = '0;
        checks++;
        if (tx_TVALID !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got v=%b want v=1", tx_TVALID);
        end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if ({tx_TVALID, grant_idx, beat_cnt} !== '0 || tx_TDATA !== '0 || rx_TREADY !== '0) begin
            errors++;
            $display("FAIL midrst_async got v=%b g=%0d cnt=%0d ready=%b want all zero",
                     tx_TVALID, grant_idx, beat_cnt, rx_TREADY);
        end
        @(posedge aclk); #1;
        aresetn   = 1'b1;
        tx_TREADY = 1'b1;
        rx_TVALID = 5'b00101;
        @(negedge aclk);
        checks++;
        if (rx_TREADY !== 5'b00001) begin
            errors++;
            $display("FAIL midrst_first_ready got=%b want=00001", rx_TREADY);
        end
        @(posedge aclk); #1 rx_TVALID = '0;
        checks++;
        if (grant_idx !== 3'd0 || tx_TDATA !== beat_of(0, 4)) begin
            errors++;
            $display("FAIL midrst_first_grant got g=%0d data=%h want g=0 data=%h",
                     grant_idx, tx_TDATA, beat_of(0, 4));
        end
        @(posedge aclk); #1;
        checks++;
        if (tx_TVALID !== 1'b0 || beat_cnt !== 32'd1) begin
            errors++;
            $display("FAIL midrst_no_replay got v=%b cnt=%0d want v=0 cnt=1", tx_TVALID, beat_cnt);
        end
    endtask

    task automatic test_loopback();
        logic [PW-1:0] exp_seq [4];
`ifdef OMNI_ARB_LOOPBACK_PRIO_EN
        exp_seq = '{3'd4, 3'd4, 3'd4, 3'd4};
`else
        exp_seq = '{3'd1, 3'd4, 3'd1, 3'd4};
`endif
        reset_dut();
        set_data(5);
        rx_TVALID = 5'b10010;
        for (int i = 0; i < 4; i++) begin
            @(posedge aclk); #1;
            checks++;
            if (grant_idx !== exp_seq[i]) begin
                errors++;
                $display("FAIL lb_seq[%0d] got=%0d want=%0d", i, grant_idx, exp_seq[i]);
            end
        end
        rx_TVALID = 5'b00010;
        @(posedge aclk); #1 rx_TVALID = '0;
        checks++;
        if (grant_idx !== 3'd1) begin
            errors++;
            $display("FAIL lb_drop got=%0d want=1", grant_idx);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_cnt_wrap();
        @(posedge aclk); #1;
        force dut.beat_cnt = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        #1 release dut.beat_cnt;
        set_data(6);
        rx_TVALID = 5'b00100;
        @(posedge aclk); #1 rx_TVALID = '0;
        checks++;
        if (beat_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload got=%h want=ffffffff", beat_cnt);
        end
        @(posedge aclk); #1;
        checks++;
        if (beat_cnt !== 32'd0 || tx_TVALID !== 1'b0) begin
            errors++;
            $display("FAIL wrap_zero got cnt=%h v=%b want cnt=0 v=0", beat_cnt, tx_TVALID);
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_loopback();
        test_cnt_wrap();
        repeat (2) @(posedge aclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
